// File: rtl/kamus_lsu_mem.sv
// Load/store MEM stage: drives the L1D req/gnt/rvalid bus, aligns store lanes,
// extends load data and holds the pipeline while an access is outstanding.
module kamus_lsu_mem #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_exmem_i,
  input  logic                  mem_rd_exmem_i,
  input  logic                  mem_wr_exmem_i,
  input  logic [2:0]            funct3_exmem_i,
  input  logic [31:0]           alu_rslt_exmem_i,
  input  logic [31:0]           rs2_data_exmem_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_exmem_i,
  input  logic                  regfile_wr_en_exmem_i,
  input  logic [1:0]            wb_mux_sel_exmem_i,
  output logic                  stall_o,
  output logic                  l1d_req_o,
  input  logic                  l1d_gnt_i,
  output logic                  l1d_we_o,
  output logic [3:0]            l1d_be_o,
  output logic [ADDR_W-1:0]     l1d_addr_o,
  output logic [31:0]           l1d_wr_data_o,
  input  logic                  l1d_rvalid_i,
  input  logic [31:0]           l1d_rd_data_i,
  output logic                  regfile_wr_en_memwb_reg_o,
  output logic [31:0]           alu_memwb_reg_o,
  output logic [31:0]           l1d_rd_data_memwb_reg_o,
  output logic [1:0]            wb_mux_sel_memwb_reg_o,
  output logic [REG_ADDR_W-1:0] rd_addr_memwb_reg_o,
  output logic                  misalign_memwb_reg_o,
  output logic                  bus_err_memwb_reg_o
);
  localparam int CNT_W = $clog2(GNT_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [31:0]             alu_q, alu_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic [1:0]              wb_sel_q, wb_sel_d;
  logic [REG_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                    misalign_q, misalign_d;
  logic                    bus_err_q, bus_err_d;

  logic        mem_op, is_st, mis, req, stall, mis_evt, berr_evt;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata, ld_sh, ld_ext;
  logic [15:0] ld_h;

  assign mem_op = valid_exmem_i & (mem_rd_exmem_i | mem_wr_exmem_i);
  assign is_st  = mem_wr_exmem_i;
  assign off    = alu_rslt_exmem_i[1:0];
  assign ld_sh  = l1d_rd_data_i >> {off, 3'b000};
  assign ld_h   = off[1] ? l1d_rd_data_i[31:16] : l1d_rd_data_i[15:0];

  always_comb begin
    mis    = 1'b1;
    be     = 4'hF;
    wdata  = rs2_data_exmem_i;
    ld_ext = l1d_rd_data_i;
    case (funct3_exmem_i)
      3'b000, 3'b100: mis = 1'b0;
      3'b001, 3'b101: mis = off[0];
      3'b010:         mis = |off;
      default:        mis = 1'b1;
    endcase
    if (is_st) begin
      case (funct3_exmem_i[1:0])
        2'b00: begin
          be    = 4'b0001 << off;
          wdata = {4{rs2_data_exmem_i[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << off;
          wdata = {2{rs2_data_exmem_i[15:0]}};
        end
        default: ;
      endcase
    end
    case (funct3_exmem_i)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b100:  ld_ext = {24'h0, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = l1d_rd_data_i;
    endcase
  end

  // Bus handshake: a request is accepted on a cycle where l1d_req_o & l1d_gnt_i;
  // the single response (load data or store ack) is the later l1d_rvalid_i
  // pulse. Address/be/data/we come from EX/MEM, which stall_o holds stable.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    stall    = 1'b0;
    mis_evt  = 1'b0;
    berr_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          if (mis) begin
            mis_evt = 1'b1;
          end else begin
            req     = 1'b1;
            stall   = 1'b1;
            state_d = l1d_gnt_i ? ST_WAIT : ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (cnt_q == CNT_W'(GNT_TIMEOUT - 1)) begin
          berr_evt = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          if (l1d_gnt_i) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        stall = ~l1d_rvalid_i;
        if (l1d_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    wr_en_d    = regfile_wr_en_exmem_i & ~stall & ~mis_evt & ~berr_evt;
    alu_d      = alu_rslt_exmem_i;
    rd_data_d  = ld_ext;
    wb_sel_d   = wb_mux_sel_exmem_i;
    rd_addr_d  = rd_addr_exmem_i;
    misalign_d = mis_evt;
    bus_err_d  = berr_evt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      alu_q      <= '0;
      rd_data_q  <= '0;
      wb_sel_q   <= '0;
      rd_addr_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      alu_q      <= alu_d;
      rd_data_q  <= rd_data_d;
      wb_sel_q   <= wb_sel_d;
      rd_addr_q  <= rd_addr_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Reset gates the combinational bus side so it reads idle while rst_ni is low.
  assign stall_o       = rst_ni & stall;
  assign l1d_req_o     = rst_ni & req;
  assign l1d_we_o      = rst_ni & is_st;
  assign l1d_be_o      = rst_ni ? be : 4'h0;
  assign l1d_addr_o    = rst_ni ? {alu_rslt_exmem_i[ADDR_W-1:2], 2'b00} : '0;
  assign l1d_wr_data_o = rst_ni ? wdata : 32'h0;

  assign regfile_wr_en_memwb_reg_o = wr_en_q;
  assign alu_memwb_reg_o           = alu_q;
  assign l1d_rd_data_memwb_reg_o   = rd_data_q;
  assign wb_mux_sel_memwb_reg_o    = wb_sel_q;
  assign rd_addr_memwb_reg_o       = rd_addr_q;
  assign misalign_memwb_reg_o      = misalign_q;
  assign bus_err_memwb_reg_o       = bus_err_q;
endmodule

// File: tb/tb_kamus_lsu_mem.sv
// Directed bench for kamus_lsu_mem: vector table for single-cycle ops, hand
// sequences for loads, stores, grant timeout and reset during an access.
module tb_kamus_lsu_mem;
  logic        clk, rst_n;
  logic        valid, mrd, mwr, wen;
  logic [2:0]  f3;
  logic [31:0] alu, rs2;
  logic [4:0]  rda;
  logic [1:0]  wbs;
  logic        stall, req, gnt, we, rvalid;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        wen_o, mis_o, berr_o;
  logic [31:0] alu_o, rdd_o;
  logic [1:0]  wbs_o;
  logic [4:0]  rda_o;

  int n_chk = 0;
  int n_fail = 0;

  kamus_lsu_mem #(.ADDR_W(32), .REG_ADDR_W(5), .GNT_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_exmem_i(valid), .mem_rd_exmem_i(mrd), .mem_wr_exmem_i(mwr),
    .funct3_exmem_i(f3), .alu_rslt_exmem_i(alu), .rs2_data_exmem_i(rs2),
    .rd_addr_exmem_i(rda), .regfile_wr_en_exmem_i(wen), .wb_mux_sel_exmem_i(wbs),
    .stall_o(stall), .l1d_req_o(req), .l1d_gnt_i(gnt), .l1d_we_o(we),
    .l1d_be_o(be), .l1d_addr_o(addr), .l1d_wr_data_o(wdata),
    .l1d_rvalid_i(rvalid), .l1d_rd_data_i(rdata),
    .regfile_wr_en_memwb_reg_o(wen_o), .alu_memwb_reg_o(alu_o),
    .l1d_rd_data_memwb_reg_o(rdd_o), .wb_mux_sel_memwb_reg_o(wbs_o),
    .rd_addr_memwb_reg_o(rda_o), .misalign_memwb_reg_o(mis_o),
    .bus_err_memwb_reg_o(berr_o)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v, rd, wr;
    logic [2:0]  f3;
    logic [31:0] alu, rs2;
    logic [4:0]  rda;
    logic        wen;
    logic [1:0]  wbs;
    logic        e_mis, e_wen;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] data, exp;
  } ld_t;

  vec_t vecs[10];
  ld_t  lds[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    valid = x.v; mrd = x.rd; mwr = x.wr; f3 = x.f3; alu = x.alu; rs2 = x.rs2;
    rda = x.rda; wen = x.wen; wbs = x.wbs;
  endtask

  task automatic set_idle();
    valid = 0; mrd = 0; mwr = 0; f3 = 3'b000; alu = 0; rs2 = 0;
    rda = 0; wen = 0; wbs = 0;
  endtask

  task automatic do_load(input ld_t l);
    valid = 1; mrd = 1; mwr = 0; f3 = l.f3; alu = l.a; rs2 = 0;
    rda = 5'd12; wen = 1; wbs = 2'b01; gnt = 1;
    @(negedge clk);
    chk("ld_req", 32'(req), 32'd1);
    chk("ld_stall_c0", 32'(stall), 32'd1);
    chk("ld_addr", addr, {l.a[31:2], 2'b00});
    chk("ld_be", 32'(be), 32'hF);
    chk("ld_we", 32'(we), 32'd0);
    step();
    chk("ld_bubble_wen", 32'(wen_o), 32'd0);
    gnt = 0; rvalid = 1; rdata = l.data;
    @(negedge clk);
    chk("ld_stall_c1", 32'(stall), 32'd0);
    chk("ld_req_c1", 32'(req), 32'd0);
    step();
    rvalid = 0; rdata = 0;
    set_idle();
    chk("ld_data", rdd_o, l.exp);
    chk("ld_wen", 32'(wen_o), 32'd1);
    chk("ld_rda", 32'(rda_o), 32'd12);
  endtask

  initial begin
    //             v  rd wr f3      alu           rs2  rda wen wbs  mis wen
    vecs[0] = '{1'b1,1'b0,1'b0,3'b000,32'h0000_1234,32'h0,5'd5, 1'b1,2'b00,1'b0,1'b1};
    vecs[1] = '{1'b0,1'b1,1'b0,3'b010,32'hABCD_0001,32'h0,5'd7, 1'b0,2'b01,1'b0,1'b0};
    vecs[2] = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0301,32'h0,5'd3, 1'b1,2'b01,1'b1,1'b0};
    vecs[3] = '{1'b1,1'b1,1'b0,3'b011,32'h0000_0300,32'h0,5'd3, 1'b1,2'b01,1'b1,1'b0};
    vecs[4] = '{1'b1,1'b1,1'b0,3'b001,32'h0000_0101,32'h0,5'd8, 1'b1,2'b01,1'b1,1'b0};
    vecs[5] = '{1'b1,1'b0,1'b1,3'b010,32'h0000_0102,32'h5,5'd0, 1'b0,2'b00,1'b1,1'b0};
    vecs[6] = '{1'b1,1'b1,1'b0,3'b101,32'h0000_0003,32'h0,5'd9, 1'b1,2'b01,1'b1,1'b0};
    vecs[7] = '{1'b1,1'b1,1'b0,3'b110,32'h0000_0000,32'h0,5'd10,1'b1,2'b01,1'b1,1'b0};
    vecs[8] = '{1'b1,1'b0,1'b1,3'b111,32'h0000_0010,32'h0,5'd0, 1'b0,2'b00,1'b1,1'b0};
    vecs[9] = '{1'b1,1'b0,1'b0,3'b000,32'hFFFF_FFFF,32'h0,5'd31,1'b1,2'b10,1'b0,1'b1};

    lds[0] = '{32'h103, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80};
    lds[1] = '{32'h103, 3'b100, 32'h80FF_0000, 32'h0000_0080};
    lds[2] = '{32'h102, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF};
    lds[3] = '{32'h100, 3'b101, 32'h1234_8001, 32'h0000_8001};
    lds[4] = '{32'h104, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D};
    lds[5] = '{32'h101, 3'b000, 32'h0000_7F00, 32'h0000_007F};

    // reset with an aligned load presented: bus side must stay idle
    rst_n = 0; gnt = 0; rvalid = 0; rdata = 0;
    set_idle();
    valid = 1; mrd = 1; f3 = 3'b010; alu = 32'h100; wen = 1;
    #3;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wen", 32'(wen_o), 32'd0);
    chk("rst_alu", alu_o, 32'd0);
    chk("rst_mis", 32'(mis_o), 32'd0);
    chk("rst_berr", 32'(berr_o), 32'd0);
    step();
    set_idle();
    step();
    rst_n = 1;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      chk($sformatf("vec%0d_req", i), 32'(req), 32'd0);
      step();
      chk($sformatf("vec%0d_mis", i), 32'(mis_o), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d_wen", i), 32'(wen_o), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d_alu", i), alu_o, vecs[i].alu);
      chk($sformatf("vec%0d_rda", i), 32'(rda_o), 32'(vecs[i].rda));
      chk($sformatf("vec%0d_wbs", i), 32'(wbs_o), 32'(vecs[i].wbs));
      chk($sformatf("vec%0d_berr", i), 32'(berr_o), 32'd0);
    end
    set_idle();
    step();
    chk("mis_clears", 32'(mis_o), 32'd0);

    foreach (lds[i]) do_load(lds[i]);

    // SH with grant after 3 cycles; stray rvalid while in REQ is ignored
    valid = 1; mrd = 0; mwr = 1; f3 = 3'b001; alu = 32'h202; rs2 = 32'hDEAD_BEEF;
    rda = 0; wen = 0; wbs = 0;
    for (int i = 0; i < 4; i++) begin
      gnt = (i == 3);
      rvalid = (i == 1);
      @(negedge clk);
      chk("sh_req", 32'(req), 32'd1);
      chk("sh_stall", 32'(stall), 32'd1);
      chk("sh_addr", addr, 32'h200);
      chk("sh_be", 32'(be), 32'hC);
      chk("sh_wdata", wdata, 32'hBEEF_BEEF);
      chk("sh_we", 32'(we), 32'd1);
      step();
      chk("sh_bubble_wen", 32'(wen_o), 32'd0);
    end
    gnt = 0; rvalid = 0;
    @(negedge clk);
    chk("sh_wait_stall", 32'(stall), 32'd1);
    chk("sh_wait_req", 32'(req), 32'd0);
    step();
    rvalid = 1;
    @(negedge clk);
    chk("sh_ack_stall", 32'(stall), 32'd0);
    step();
    rvalid = 0;
    set_idle();
    chk("sh_done_alu", alu_o, 32'h202);
    chk("sh_done_wen", 32'(wen_o), 32'd0);

    // SB with rd and wr both high behaves as a store
    valid = 1; mrd = 1; mwr = 1; f3 = 3'b000; alu = 32'h201; rs2 = 32'h1234_56A5;
    gnt = 1;
    @(negedge clk);
    chk("sb_we", 32'(we), 32'd1);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wdata, 32'hA5A5_A5A5);
    step();
    gnt = 0; rvalid = 1;
    @(negedge clk);
    chk("sb_ack_stall", 32'(stall), 32'd0);
    step();
    rvalid = 0;
    set_idle();

    // grant timeout: req held GNT_TIMEOUT cycles, then bus error
    valid = 1; mrd = 1; f3 = 3'b010; alu = 32'h400; rda = 5'd6; wen = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("to_req%0d", i), 32'(req), 32'd1);
      step();
      chk($sformatf("to_wen%0d", i), 32'(wen_o), 32'd0);
    end
    @(negedge clk);
    chk("to_req_drop", 32'(req), 32'd0);
    chk("to_stall_drop", 32'(stall), 32'd0);
    step();
    set_idle();
    chk("to_berr", 32'(berr_o), 32'd1);
    chk("to_berr_wen", 32'(wen_o), 32'd0);
    step();
    chk("to_berr_clear", 32'(berr_o), 32'd0);
    @(negedge clk);
    chk("to_idle_stall", 32'(stall), 32'd0);

    // reset pulsed during WAIT, stray rvalid afterwards
    step();
    valid = 1; mrd = 1; f3 = 3'b010; alu = 32'h500; rda = 5'd9; wen = 1; gnt = 1;
    step();
    gnt = 0;
    @(negedge clk);
    chk("rw_wait_stall", 32'(stall), 32'd1);
    #2;
    rst_n = 0;
    set_idle();
    #1;
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_req", 32'(req), 32'd0);
    chk("rw_alu", alu_o, 32'd0);
    chk("rw_wen", 32'(wen_o), 32'd0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rw_post_stall", 32'(stall), 32'd0);
    step();
    rvalid = 1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rw_stray_stall", 32'(stall), 32'd0);
    chk("rw_stray_req", 32'(req), 32'd0);
    step();
    rvalid = 0;
    chk("rw_stray_wen", 32'(wen_o), 32'd0);
    chk("rw_stray_mis", 32'(mis_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
